// File: rtl/mem_arbiter_if.sv
// Bundle of the core, loader and data-memory signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int DATA_LENGTH      = 32,
    parameter int DMEM_ADDR_LENGTH = 32
);
    logic                        c_req;
    logic                        c_we;
    logic [DMEM_ADDR_LENGTH-1:0] c_addr;
    logic [DATA_LENGTH-1:0]      c_wdata;
    logic                        c_gnt;
    logic                        c_stall;
    logic                        c_rvalid;
    logic [DATA_LENGTH-1:0]      c_rdata;

    logic                        l_req;
    logic                        l_we;
    logic [DMEM_ADDR_LENGTH-1:0] l_addr;
    logic [DATA_LENGTH-1:0]      l_wdata;
    logic                        l_gnt;
    logic                        l_rvalid;
    logic [DATA_LENGTH-1:0]      l_rdata;

    logic [DMEM_ADDR_LENGTH-1:0] m_addr;
    logic [DATA_LENGTH-1:0]      m_wdata;
    logic                        m_we;
    logic [DATA_LENGTH-1:0]      m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output m_addr, m_wdata, m_we,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  m_addr, m_wdata, m_we,
        output m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter: core has fixed priority, the loader is
// forced in after MAX_WAIT consecutive core wins. Reads return one cycle later.
module mem_arbiter #(
    parameter int DATA_LENGTH      = 32,
    parameter int DMEM_ADDR_LENGTH = 32,
    parameter int MAX_WAIT         = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0]               wait_cnt;
    logic                        rd_pend;
    logic                        rd_owner;   // 0 = core, 1 = loader
    logic                        starve;
    logic                        c_gnt;
    logic                        l_gnt;
    logic [DMEM_ADDR_LENGTH-1:0] addr_sel;
    logic [DATA_LENGTH-1:0]      wdata_sel;

    assign starve = (wait_cnt == CW'(MAX_WAIT));

    // Grants are forced low during reset so nothing reaches memory.
    always_comb begin
        l_gnt = 1'b0;
        c_gnt = 1'b0;
        if (!rst) begin
            l_gnt = bus.l_req & (~bus.c_req | starve);
            c_gnt = bus.c_req & ~l_gnt;
        end
    end

    assign addr_sel  = l_gnt ? bus.l_addr  : bus.c_addr;
    assign wdata_sel = l_gnt ? bus.l_wdata : bus.c_wdata;

    assign bus.c_gnt   = c_gnt;
    assign bus.l_gnt   = l_gnt;
    assign bus.c_stall = bus.c_req & ~c_gnt;
    assign bus.m_addr  = addr_sel;
    assign bus.m_wdata = wdata_sel;
    assign bus.m_we    = (c_gnt & bus.c_we) | (l_gnt & bus.l_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (l_gnt || !bus.l_req) begin
            wait_cnt <= '0;
        end else if (c_gnt && wait_cnt != CW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (c_gnt & ~bus.c_we) | (l_gnt & ~bus.l_we);
            rd_owner <= l_gnt;
        end
    end

    // Memory data is shared; only the owner's rvalid qualifies it.
    assign bus.c_rvalid = rd_pend & ~rd_owner;
    assign bus.l_rvalid = rd_pend &  rd_owner;
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.l_rdata  = bus.m_rdata;
endmodule
